// File: rtl/uart_pkg.sv
//----------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared UART register bit positions, word-length codes, parity.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_PEN     = 3;
  localparam int LCR_EPS     = 4;
  localparam int LCR_SP      = 5;
  localparam int FCR_FIFO_EN = 0;
  localparam int FCR_TX_CLR  = 2;

  localparam logic [1:0] WL_5 = 2'd0;
  localparam logic [1:0] WL_6 = 2'd1;
  localparam logic [1:0] WL_7 = 2'd2;
  localparam logic [1:0] WL_8 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tx_state_e;

  // Parity over the active data bits only; stick mode forces the inverse of EPS.
  function automatic logic par_bit(input logic [7:0] data, input logic [1:0] wl,
                                   input logic even, input logic stick);
    logic [7:0] mask;
    logic       x;
    case (wl)
      WL_5:    mask = 8'h1F;
      WL_6:    mask = 8'h3F;
      WL_7:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (stick) return ~even;
    return even ? x : ~x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_fifo.sv
//----------------------------------------------------------------------------
// Module : tx_fifo
// Brief  : Synchronous TX FIFO with selectable depth (DEPTH or 1) and flush.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int LVL_W  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              clr_i,
  input  logic              depth_sel_i,
  output logic [DATA_W-1:0] data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full_o    = (level_q == (depth_sel_i ? LVL_W'(DEPTH) : LVL_W'(1)));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign w_pop_ok  = pop_i && !empty_o;
  // A same-cycle pop frees the slot, so a write on a full FIFO still lands.
  assign w_push_ok = push_i && !clr_i && (!full_o || w_pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/tx_scheduler.sv
//----------------------------------------------------------------------------
// Module : tx_scheduler
// Brief  : UART TX sequencing: buffering, framing/parity, start pulses, LSR status.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tx_scheduler
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             fifo_en,
  input  logic             fifo_clr,
  input  logic [1:0]       word_length,
  input  logic             parity_en,
  input  logic             even_parity,
  input  logic             stick_parity,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [8:0]       tx_data,
  output logic [LVL_W-1:0] tx_level,
  output logic             thre,
  output logic             temt,
  output logic             thre_event,
  output logic             overflow
);

  tx_state_e  state_q, state_d;
  logic [8:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       overflow_q, overflow_d;
  logic       fifo_en_q;
  logic       thre_prev_q;

  logic       w_clr;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;
  logic       w_par;
  logic [8:0] w_frame;

  // Switching FIFO mode discards whatever is queued, exactly like a flush.
  assign w_clr = fifo_clr || (fifo_en != fifo_en_q);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W),
    .DATA_W(8)
  ) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr_en),
    .data_i     (wr_data),
    .pop_i      (w_pop),
    .clr_i      (w_clr),
    .depth_sel_i(fifo_en),
    .data_o     (w_head),
    .level_o    (tx_level),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

  always_comb begin
    w_par = par_bit(w_head, word_length, even_parity, stick_parity) & parity_en;
    case (word_length)
      WL_5:    w_frame = {3'b000, w_par, w_head[4:0]};
      WL_6:    w_frame = {2'b00, w_par, w_head[5:0]};
      WL_7:    w_frame = {1'b0, w_par, w_head[6:0]};
      default: w_frame = {w_par, w_head};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    w_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          tx_data_d  = w_frame;
          tx_start_d = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (tx_done) state_d = ST_IDLE;
      end
    endcase
    overflow_d = wr_en && !w_clr && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      overflow_q  <= 1'b0;
      fifo_en_q   <= 1'b0;
      thre_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      overflow_q  <= overflow_d;
      fifo_en_q   <= fifo_en;
      thre_prev_q <= thre;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign thre       = w_empty;
  assign temt       = w_empty && (state_q == ST_IDLE);
  assign thre_event = w_empty && !thre_prev_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_scheduler.sv
//----------------------------------------------------------------------------
// Module : tb_tx_scheduler
// Brief  : Queue-based reference model plus directed and random stimulus for tx_scheduler.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_tx_scheduler;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic [7:0]       lcr = 8'h03;
  logic [7:0]       fcr = 8'h00;
  logic             tx_done = 1'b0;
  logic             fifo_en, fifo_clr, parity_en, even_parity, stick_parity;
  logic [1:0]       word_length;
  logic             tx_start, thre, temt, thre_event, overflow;
  logic [8:0]       tx_data;
  logic [LVL_W-1:0] tx_level;

  assign word_length  = lcr[LCR_WLS_LSB +: 2];
  assign parity_en    = lcr[LCR_PEN];
  assign even_parity  = lcr[LCR_EPS];
  assign stick_parity = lcr[LCR_SP];
  assign fifo_en      = fcr[FCR_FIFO_EN];
  assign fifo_clr     = fcr[FCR_TX_CLR];

  tx_scheduler #(.FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_en(fifo_en), .fifo_clr(fifo_clr), .word_length(word_length),
    .parity_en(parity_en), .even_parity(even_parity), .stick_parity(stick_parity),
    .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data), .tx_level(tx_level),
    .thre(thre), .temt(temt), .thre_event(thre_event), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes, transmitter busy flag, last issued frame.
  logic [7:0] q[$];
  bit         m_busy, m_start, m_ovf, m_ev, m_prev_fen;
  logic [8:0] m_data;
  int         total = 0;
  int         bad = 0;
  bit         chk_en = 1'b0;

  function automatic logic [8:0] frame_of(input logic [7:0] b, input logic [7:0] l);
    int n    = 5 + int'(l[1:0]);
    int d    = int'(b) % (1 << n);
    int ones = $countones(d);
    bit p;
    if (l[LCR_SP]) p = !l[LCR_EPS];
    else           p = l[LCR_EPS] ? ones[0] : !ones[0];
    return 9'(d + ((l[LCR_PEN] && p) ? (1 << n) : 0));
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_start = 0; m_ovf = 0; m_ev = 0; m_prev_fen = 0; m_data = '0;
  endtask

  task automatic model_update();
    int sz0   = q.size();
    int depth = fifo_en ? DEPTH : 1;
    bit flush = fifo_clr || (fifo_en != m_prev_fen);
    bit pop   = 0;
    m_prev_fen = fifo_en;
    m_start = 0;
    m_ovf   = 0;
    if (!m_busy) begin
      if (sz0 != 0) begin
        m_data  = frame_of(q.pop_front(), lcr);
        m_start = 1; m_busy = 1; pop = 1;
      end
    end else if (tx_done) begin
      m_busy = 0;
    end
    if (flush) q.delete();
    else if (wr_en) begin
      if (sz0 < depth || pop) q.push_back(wr_data);
      else m_ovf = 1;
    end
    m_ev = (q.size() == 0) && (sz0 != 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_start", int'(tx_start), int'(m_start));
      chk("tx_data", int'(tx_data), int'(m_data));
      chk("tx_level", int'(tx_level), q.size());
      chk("thre", int'(thre), int'(q.size() == 0));
      chk("temt", int'(temt), int'(q.size() == 0 && !m_busy));
      chk("thre_event", int'(thre_event), int'(m_ev));
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    #1;
  endtask

  task automatic wr1(input logic [7:0] b);
    wr_en = 1; wr_data = b; cyc(); wr_en = 0;
  endtask

  task automatic done1();
    tx_done = 1; cyc(); tx_done = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_cnt;
    int got;
    model_reset();
    chk_en = 1;
    repeat (2) cyc();
    rst_n = 1;
    chk("rst_thre", int'(thre), 1);
    chk("rst_temt", int'(temt), 1);
    chk("rst_level", int'(tx_level), 0);
    cyc();

    // 1: single byte, WL=8, no parity
    wr1(8'h55);
    chk("t1_level", int'(tx_level), 1);
    chk("t1_thre_low", int'(thre), 0);
    cyc();
    chk("t1_start", int'(tx_start), 1);
    chk("t1_data", int'(tx_data), 9'h055);
    chk("t1_thre_event", int'(thre_event), 1);
    chk("t1_temt_busy", int'(temt), 0);
    repeat (3) cyc();
    done1();
    chk("t1_temt_done", int'(temt), 1);

    // 2: parity framing
    lcr = 8'h1A; wr1(8'hFF); cyc();
    chk("t2_even", int'(tx_data), 9'h0FF); done1();
    lcr = 8'h0A; wr1(8'hFF); cyc();
    chk("t2_odd", int'(tx_data), 9'h07F); done1();
    lcr = 8'h3A; wr1(8'hFF); cyc();
    chk("t2_stick_even", int'(tx_data), 9'h07F); done1();
    lcr = 8'h28; wr1(8'hFF); cyc();
    chk("t2_stick_odd_wl5", int'(tx_data), 9'h03F); done1();
    lcr = 8'h03;

    // 3: FIFO burst of 17 while busy
    fcr = 8'h01; cyc();
    wr1(8'hA0); cyc();
    ovf_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = 8'(i); cyc(); ovf_cnt += int'(overflow);
    end
    wr_en = 0;
    chk("t3_level_full", int'(tx_level), 16);
    chk("t3_ovf_count", ovf_cnt, 1);
    tx_done = 1; got = 0;
    for (int k = 0; k < 100 && got < 16; k++) begin
      cyc();
      if (tx_start) begin
        chk("t3_order", int'(tx_data), got);
        got++;
      end
    end
    cyc(); tx_done = 0;
    chk("t3_frames", got, 16);

    // 4: holding register mode
    fcr = 8'h00; cyc();
    wr1(8'h11); cyc();
    wr1(8'h22); wr1(8'h33);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_level", int'(tx_level), 1);
    done1(); cyc();
    chk("t4_next", int'(tx_data), 9'h022);
    done1(); cyc();

    // 5: flush mid-frame
    fcr = 8'h01; cyc();
    wr1(8'h44); cyc();
    for (int i = 0; i < 5; i++) wr1(8'(8'h50 + i));
    chk("t5_level5", int'(tx_level), 5);
    fcr = 8'h05; cyc(); fcr = 8'h01;
    chk("t5_level0", int'(tx_level), 0);
    chk("t5_event", int'(thre_event), 1);
    chk("t5_held", int'(tx_data), 9'h044);
    chk("t5_temt_busy", int'(temt), 0);
    done1();
    chk("t5_temt", int'(temt), 1);

    // 6: async reset during a frame
    wr1(8'h66); cyc();
    rst_n = 0; #1;
    chk("t6_start", int'(tx_start), 0);
    chk("t6_data", int'(tx_data), 0);
    chk("t6_thre", int'(thre), 1);
    chk("t6_temt", int'(temt), 1);
    model_reset();
    repeat (2) cyc();
    rst_n = 1;
    repeat (4) cyc();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_data = 8'($urandom);
      tx_done = ($urandom_range(0, 3) == 0);
      fcr[FCR_TX_CLR] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) fcr[FCR_FIFO_EN] = ~fcr[FCR_FIFO_EN];
      if ($urandom_range(0, 49) == 0) lcr = 8'($urandom) & 8'h3F;
      cyc();
    end
    wr_en = 0; tx_done = 0; fcr = 8'h01;
    cyc();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
